// File: rtl/pipe_stage_if.sv
// pipe_stage_if: valid/ready payload bus around a single pipe_stage.
//   in_valid/in_ready/in_data    : upstream handshake into the stage
//   out_valid/out_ready/out_data : downstream handshake out of the stage
// Modports:
//   slave  : the pipe_stage side (consumes in_*, produces out_*)
//   master : the surrounding logic (produces in_*, consumes out_*)
interface pipe_stage_if #(
  parameter int unsigned WIDTH = 133
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage.sv
// pipe_stage: two-entry (main + skid) registered pipeline stage.
//   Full-throughput valid/ready buffering in which in_ready is decoded only
//   from the state register, so it has no combinational path from out_ready
//   or in_valid. out_data is always taken from the main entry.
// Ports:
//   clk        : single clock, rising edge
//   rst        : synchronous active-low reset
//   flush      : synchronous kill of all held entries, clears stall_cnt
//   bus        : pipe_stage_if.slave (in_valid/in_ready/in_data,
//                out_valid/out_ready/out_data)
//   stall_cnt  : saturating count of cycles with out_valid=1, out_ready=0
module pipe_stage #(
  parameter int unsigned WIDTH       = 133,
  parameter bit          ZERO_BUBBLE = 1'b1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  pipe_stage_if.slave       bus,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   main_q, main_d;
  logic [WIDTH-1:0]   skid_q, skid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               in_fire;
  logic               out_fire;
  logic               out_valid;

  always_comb begin
    out_valid = (state_q != EMPTY);
    in_fire   = bus.in_valid & (state_q != FULL);
    out_fire  = out_valid & bus.out_ready;

    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = BUSY;
          main_d  = bus.in_data;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_d = bus.in_data;
        end else if (in_fire) begin
          state_d = FULL;
          skid_d  = bus.in_data;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (out_valid && !bus.out_ready && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end

    // Flush only drops occupancy; entry storage is left untouched so a
    // ZERO_BUBBLE=0 build still shows the stale main entry.
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    bus.out_valid = (state_q != EMPTY);
    bus.in_ready  = (state_q != FULL);
    if (ZERO_BUBBLE && (state_q == EMPTY)) begin
      bus.out_data = '0;
    end else begin
      bus.out_data = main_q;
    end
    stall_cnt = cnt_q;
  end

endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: self-checking bench for pipe_stage. A queue-based model
// (capacity 2, FIFO order, saturating stall counter) predicts every output.
module tb_pipe_stage;

  localparam int unsigned W    = 133;
  localparam int unsigned VW   = W + 18;
  localparam int          CMAX = 65535;

  logic clk;
  logic rst;
  logic flush;
  logic flush_b;
  logic [15:0] stall_a;
  logic [2:0]  stall_b;

  pipe_stage_if #(.WIDTH(W)) bus_a ();
  pipe_stage_if #(.WIDTH(8)) bus_b ();

  pipe_stage #(.WIDTH(W), .ZERO_BUBBLE(1'b1), .CNT_W(16)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus_a),
    .stall_cnt (stall_a)
  );

  pipe_stage #(.WIDTH(8), .ZERO_BUBBLE(1'b1), .CNT_W(3)) u_sat (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush_b),
    .bus       (bus_b),
    .stall_cnt (stall_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mq[$];
  int           mcnt = 0;

  // Reference model: applies one clock edge using the currently driven inputs.
  task automatic model_edge();
    bit ofire, ifire;
    if (!rst) begin
      mq.delete();
      mcnt = 0;
    end else begin
      ofire = (mq.size() > 0) && bus_a.out_ready;
      ifire = bus_a.in_valid && (mq.size() < 2);
      if ((mq.size() > 0) && !bus_a.out_ready && (mcnt < CMAX)) mcnt++;
      if (flush) begin
        mq.delete();
        mcnt = 0;
      end else begin
        if (ofire) void'(mq.pop_front());
        if (ifire) mq.push_back(bus_a.in_data);
      end
    end
  endtask

  function automatic logic [VW-1:0] expv();
    logic [W-1:0] d;
    d = (mq.size() > 0) ? mq[0] : '0;
    return {mq.size() > 0, mq.size() < 2, d, 16'(mcnt)};
  endfunction

  function automatic logic [VW-1:0] actv();
    return {bus_a.out_valid, bus_a.in_ready, bus_a.out_data, stall_a};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    logic [VW-1:0] want;
    rst = 1'b0; flush = 1'b0; flush_b = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;
    cyc();
    rst = 1'b1;
    want = {1'b0, 1'b1, {W{1'b0}}, 16'd0};
    checks++;
    if (actv() !== want) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", actv(), want);
    end
    checks++;
    if ({bus_b.out_valid, bus_b.in_ready, stall_b} !== 5'b01000) begin
      errors++;
      $display("FAIL reset_sat_dut: got %b want 01000", {bus_b.out_valid, bus_b.in_ready, stall_b});
    end
  endtask

  task automatic test_streaming();
    bus_a.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = W'(i);
      cyc();
      checks++;
      if (actv() !== expv() || bus_a.out_data !== W'(i) || bus_a.in_ready !== 1'b1 || stall_a !== 16'd0) begin
        errors++;
        $display("FAIL stream_%0d: got %h want %h", i, actv(), expv());
      end
    end
    bus_a.in_valid = 1'b0;
    cyc();
    checks++;
    if (actv() !== expv() || bus_a.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain: got %h want %h", actv(), expv());
    end
  endtask

  task automatic test_skid_fill();
    bus_a.out_ready = 1'b1; bus_a.in_valid = 1'b1; bus_a.in_data = W'(8'hA);
    cyc();
    bus_a.out_ready = 1'b0; bus_a.in_data = W'(8'hB);
    cyc();
    checks++;
    if (actv() !== expv() || bus_a.in_ready !== 1'b0 || bus_a.out_data !== W'(8'hA)) begin
      errors++;
      $display("FAIL skid_full: got %h want %h", actv(), expv());
    end
    bus_a.in_data = W'(8'hC);
    cyc();
    checks++;
    if (actv() !== expv() || stall_a !== 16'd2 || bus_a.out_data !== W'(8'hA)) begin
      errors++;
      $display("FAIL skid_stall2: got stall %0d data %h want stall 2 data a", stall_a, bus_a.out_data);
    end
    bus_a.out_ready = 1'b1;
    cyc();
    checks++;
    if (actv() !== expv() || bus_a.out_data !== W'(8'hB)) begin
      errors++;
      $display("FAIL skid_out_b: got %h want %h", actv(), expv());
    end
    cyc();
    checks++;
    if (actv() !== expv() || bus_a.out_data !== W'(8'hC)) begin
      errors++;
      $display("FAIL skid_out_c: got %h want %h", actv(), expv());
    end
    bus_a.in_valid = 1'b0;
    cyc();
    checks++;
    if (actv() !== expv() || bus_a.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL skid_empty: got %h want %h", actv(), expv());
    end
  endtask

  task automatic test_flush_full();
    logic [VW-1:0] want;
    bus_a.out_ready = 1'b0; bus_a.in_valid = 1'b1;
    bus_a.in_data = W'(16'h1111); cyc();
    bus_a.in_data = W'(16'h2222); cyc();
    flush = 1'b1; bus_a.in_data = W'(16'h3333);
    cyc();
    flush = 1'b0; bus_a.in_valid = 1'b0;
    want = {1'b0, 1'b1, {W{1'b0}}, 16'd0};
    checks++;
    if (actv() !== want) begin
      errors++;
      $display("FAIL flush_full: got %h want %h", actv(), want);
    end
    bus_a.out_ready = 1'b1;
    cyc();
    checks++;
    if (actv() !== want) begin
      errors++;
      $display("FAIL flush_no_ghost: got %h want %h", actv(), want);
    end
    bus_a.in_valid = 1'b1; bus_a.in_data = W'(16'h4444);
    cyc();
    bus_a.in_valid = 1'b0;
    checks++;
    if (actv() !== expv() || bus_a.out_data !== W'(16'h4444)) begin
      errors++;
      $display("FAIL flush_next: got %h want %h", actv(), expv());
    end
    cyc();
  endtask

  task automatic test_saturation();
    bus_b.out_ready = 1'b0; bus_b.in_valid = 1'b1; bus_b.in_data = 8'h5A;
    cyc();
    bus_b.in_valid = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      cyc();
      checks++;
      if (stall_b !== 3'((k < 7) ? k : 7) || bus_b.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL sat_cycle_%0d: got %0d want %0d", k, stall_b, (k < 7) ? k : 7);
      end
    end
    flush_b = 1'b1;
    cyc();
    flush_b = 1'b0;
    checks++;
    if ({bus_b.out_valid, stall_b} !== 4'b0000) begin
      errors++;
      $display("FAIL sat_flush: got %b want 0000", {bus_b.out_valid, stall_b});
    end
  endtask

  task automatic test_reset_full();
    logic [VW-1:0] want;
    bus_a.out_ready = 1'b0; bus_a.in_valid = 1'b1;
    bus_a.in_data = W'(16'h0E01); cyc();
    bus_a.in_data = W'(16'h0E02); cyc();
    rst = 1'b0; bus_a.in_data = W'(16'h0E03);
    cyc();
    rst = 1'b1; bus_a.in_valid = 1'b0;
    want = {1'b0, 1'b1, {W{1'b0}}, 16'd0};
    checks++;
    if (actv() !== want) begin
      errors++;
      $display("FAIL rst_full: got %h want %h", actv(), want);
    end
    bus_a.in_valid = 1'b1; bus_a.in_data = W'(8'h55);
    cyc();
    bus_a.in_valid = 1'b0;
    checks++;
    if (actv() !== expv() || bus_a.out_data !== W'(8'h55) || bus_a.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_first: got %h want %h", actv(), expv());
    end
    bus_a.out_ready = 1'b1;
    cyc();
    checks++;
    if (actv() !== want) begin
      errors++;
      $display("FAIL rst_alone: got %h want %h", actv(), want);
    end
  endtask

  task automatic test_random();
    logic [159:0] r;
    logic         rdy_before;
    for (int n = 0; n < 10000; n++) begin
      rst   = ($urandom_range(0, 499) != 0);
      flush = ($urandom_range(0, 49) == 0);
      bus_a.in_valid  = ($urandom_range(0, 3) != 0);
      bus_a.out_ready = ($urandom_range(0, 2) != 0);
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      bus_a.in_data = r[W-1:0];
      rdy_before = bus_a.in_ready;
      bus_a.out_ready = ~bus_a.out_ready;
      bus_a.in_valid  = ~bus_a.in_valid;
      #1;
      checks++;
      if (bus_a.in_ready !== rdy_before) begin
        errors++;
        $display("FAIL rand_ready_comb_%0d: got %b want %b", n, bus_a.in_ready, rdy_before);
      end
      bus_a.out_ready = ~bus_a.out_ready;
      bus_a.in_valid  = ~bus_a.in_valid;
      cyc();
      checks++;
      if (actv() !== expv()) begin
        errors++;
        $display("FAIL rand_%0d: got %h want %h", n, actv(), expv());
      end
    end
    rst = 1'b1; flush = 1'b0; bus_a.in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_skid_fill();
    test_flush_full();
    test_saturation();
    test_reset_full();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter WIDTH, default 133, payload bits per entry (pc_4 32 + ym 32 + mdr 32 + ctrl 32 + rd 5).
REQ-002 Parameter ZERO_BUBBLE, default 1; when 1, out_data reads all-zero whenever out_valid=0.
REQ-003 Parameter CNT_W, default 16, width of the stall counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low: rst=0 at a rising edge of clk resets the block.
REQ-006 flush  input  1  synchronous kill of all held entries.
REQ-007 in_valid  input  1  upstream payload valid.
REQ-008 in_ready  output  1  stage can accept a payload this cycle.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 out_valid  output  1  out_data holds a valid payload.
REQ-011 out_ready  input  1  downstream accepts this cycle.
REQ-012 out_data  output  WIDTH  payload to downstream.
REQ-013 stall_cnt  output  CNT_W  saturating count of back-pressured cycles.

Function
REQ-014 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready; transfers occur only on fire.
REQ-015 Storage: two WIDTH-bit entries, main and skid; out_data is driven from main only.
REQ-016 States: EMPTY (no entries), BUSY (main valid), FULL (main and skid valid); out_valid = (state != EMPTY).
REQ-017 in_ready = (state != FULL), decoded from the state register only; no combinational path from out_ready or in_valid to in_ready.
REQ-018 EMPTY: in_fire -> BUSY, main <= in_data.
REQ-019 BUSY: in_fire & out_fire -> BUSY, main <= in_data; in_fire only -> FULL, skid <= in_data; out_fire only -> EMPTY; neither -> hold.
REQ-020 FULL: out_fire -> BUSY, main <= skid; otherwise hold; no input accepted.
REQ-021 Latency: a payload accepted at edge N appears on out_data with out_valid=1 after edge N (one cycle); throughput one payload per cycle while out_ready=1.
REQ-022 Order: payloads leave in acceptance order; none dropped or duplicated except by flush.
REQ-023 flush=1 at an edge forces state EMPTY, overriding all transitions; payloads in-flight that cycle (including an in_fire) are discarded.
REQ-024 Entry contents not overwritten by flush; with ZERO_BUBBLE=1 they are masked, with ZERO_BUBBLE=0 out_data shows stale main.
REQ-025 stall_cnt increments by 1 at each edge where out_valid=1 and out_ready=0; saturates at 2^CNT_W-1 with no wrap.
REQ-026 flush clears stall_cnt to 0; flush has priority over increment in the same cycle.
REQ-027 out_valid/out_data change only at clock edges (registered outputs).

Reset
REQ-028 rst=0 at an edge: state EMPTY, main and skid 0, stall_cnt 0; overrides flush and any handshake that cycle.
REQ-029 Following reset edge: out_valid=0, out_data=0, in_ready=1, stall_cnt=0.
REQ-030 Reset asserted mid-operation (FULL) discards both entries; first payload after rst=1 is the next accepted in_data.

Verification
REQ-031 Streaming: out_ready=1, in_valid=1 with in_data=1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later each, in_ready stays 1, stall_cnt=0.
REQ-032 Skid fill: accept 0xA, hold out_ready=0, offer 0xB, 0xC -> 0xB enters skid, in_ready=0 after, 0xC held upstream; release out_ready -> outputs 0xA,0xB,0xC in order; stall_cnt=2 at release.
REQ-033 Flush in FULL with simultaneous in_valid -> next cycle out_valid=0, out_data=0 (ZERO_BUBBLE=1), in_ready=1, stall_cnt=0; flushed payloads never appear.
REQ-034 Saturation: CNT_W=3, out_valid=1, out_ready=0 for 10 cycles -> stall_cnt reads 7 and holds.
REQ-035 Reset in FULL: drive rst=0 one cycle with flush=0 -> out_valid=0, in_ready=1, stall_cnt=0; next accepted 0x55 emerges alone.
REQ-036 Random valid/ready stress, 10000 cycles vs. scoreboard queue -> zero mismatches, no in_ready combinational dependence on out_ready.
